wb_sched: RTL and testbench
===========================

WB_SCHED -- requirements
Module: wb_sched

Interface
REQ-001 SHALL have parameter NREQ, default 3, number of writeback requesters; fixed at 3 in this revision.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  3  requester i holds a write pending (0=ALU, 1=MUL, 2=LD).
REQ-005 SHALL have port req_addr  input  9  requester i destination register, bits [3i+2:3i].
REQ-006 SHALL have port req_data  input  24  requester i write data, bits [8i+7:8i].
REQ-007 SHALL have port req_ready  output  3  requester i accepted this cycle; combinational.
REQ-008 SHALL have port hold  input  1  pipeline stall; blocks all grants.
REQ-009 SHALL have ports we3/wa3/wd3  output  1/3/8  register-file write port 3; registered.
REQ-010 SHALL have ports we4/wa4/wd4  output  1/3/8  register-file write port 4; registered.
REQ-011 SHALL have port stall_cnt  output  8  saturating count of cycles with at least one unserved valid request.

Function
REQ-012 SHALL perform a transfer for requester i only in a cycle where req_valid[i]=1 and req_ready[i]=1; a requester holds valid, addr and data stable until ready.
REQ-013 SHALL keep a 2-bit round-robin pointer ptr in {0,1,2}; the priority order is ptr, ptr+1, ptr+2 (mod 3).
REQ-014 SHALL grant the first valid requester in priority order to port 3 (slot A).
REQ-015 SHALL grant the next valid requester in priority order to port 4 (slot B) only if its address differs from slot A's address.
REQ-016 SHALL grant at most 2 requesters per cycle; a third valid requester waits.
REQ-017 SHALL grant nothing while hold=1: req_ready=0 and ptr unchanged.
REQ-018 SHALL register each granted request to its port on the next rising edge: we=1, with wa/wd equal to the accepted addr/data (latency 1 cycle).
REQ-019 SHALL register we3=0 (or we4=0) on the next edge when slot A (or slot B) has no grant; wa/wd then hold their previous values.
REQ-020 SHALL, when at least one grant occurs, set ptr to (index of the last granted requester + 1) mod 3; with no grant, ptr is unchanged.
REQ-021 SHALL not skip a requester blocked by an address conflict in slot B; it remains eligible next cycle under the updated ptr.
REQ-022 SHALL increment stall_cnt when any req_valid bit has req_ready=0 in a cycle, including cycles with hold=1, saturating at 255; it never wraps.
REQ-023 SHALL guarantee that we3 and we4 are never both 1 with wa3==wa4.
REQ-024 SHALL serve every continuously valid requester within 2 cycles while hold=0 (no starvation).

Reset
REQ-025 SHALL, while reset_n=0, force asynchronously ptr=0, we3=0, we4=0, wa3=wa4=0, wd3=wd4=0 and stall_cnt=0.
REQ-026 SHALL drive req_ready=0 while reset_n=0.
REQ-027 SHALL discard any grant in progress when reset asserts mid-cycle; no write is emitted after release.
REQ-028 SHALL begin arbitration on the first rising edge after reset_n deasserts.

Verification
REQ-029 SHALL pass this case: after reset, ptr=0, req_valid=111, addrs 1/2/3, data 0x11/0x22/0x33 -> ready=011; next edge we3=1 wa3=1 wd3=0x11, we4=1 wa4=2 wd4=0x22; ptr=2; stall_cnt=1.
REQ-030 SHALL pass this case: following cycle with only req 2 valid (addr 3, data 0x33) -> ready=100; next edge we3=1 wa3=3 wd3=0x33, we4=0; ptr=0.
REQ-031 SHALL pass this case: ptr=0, reqs 0 and 1 valid, both addr 5 -> ready=001; port 3 writes req 0; ptr=1; next cycle req 1 is granted to port 3.
REQ-032 SHALL pass this case: hold=1 for 4 cycles with req_valid=111 -> ready=000, we3=we4=0, ptr unchanged, stall_cnt increases by 4.
REQ-033 SHALL pass this case: stall_cnt=255 plus a further unserved cycle -> stall_cnt stays 255.
REQ-034 SHALL pass this case: reset_n driven low between edges after a grant -> we3/we4/stall_cnt go to 0 immediately, and the pending write never appears.

Source files
------------

// File: rtl/wb_sched_if.sv
// Requester-side bus for the writeback scheduler: per-requester valid/addr/data
// flattened into packed vectors, with a combinational ready returned per lane.
interface wb_sched_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]   req_valid;
  logic [3*NREQ-1:0] req_addr;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;

  modport master (output req_valid, req_addr, req_data, input req_ready);
  modport slave  (input req_valid, req_addr, req_data, output req_ready);
endinterface

// File: rtl/wb_sched.sv
// Writeback scheduler: round-robin arbitration of 3 requesters onto two
// register-file write ports, with address-conflict suppression on port 4.
module wb_sched #(
  parameter int NREQ = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  wb_sched_if.slave  rq,
  input  logic       hold,
  output logic       we3,
  output logic [2:0] wa3,
  output logic [7:0] wd3,
  output logic       we4,
  output logic [2:0] wa4,
  output logic [7:0] wd4,
  output logic [7:0] stall_cnt
);

  logic [NREQ-1:0][2:0] addr_v;
  logic [NREQ-1:0][7:0] data_v;
  logic [NREQ-1:0]      rdy;
  logic [1:0]           ptr, ptr_nxt, a_idx, b_idx, idx, last_idx;
  logic                 a_vld, b_vld, b_seen, unserved;

  assign addr_v = rq.req_addr;
  assign data_v = rq.req_data;

  function automatic logic [1:0] rr_idx(input logic [1:0] p, input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, p} + {1'b0, k};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  // Slot B looks only at the very next valid requester after slot A; a
  // conflicting one is left for the next cycle rather than skipped over.
  always_comb begin
    a_vld  = 1'b0;
    b_vld  = 1'b0;
    b_seen = 1'b0;
    a_idx  = 2'd0;
    b_idx  = 2'd0;
    idx    = 2'd0;
    for (int k = 0; k < 3; k++) begin
      idx = rr_idx(ptr, 2'(k));
      if (rq.req_valid[idx]) begin
        if (!a_vld) begin
          a_vld = 1'b1;
          a_idx = idx;
        end else if (!b_seen) begin
          b_seen = 1'b1;
          if (addr_v[idx] != addr_v[a_idx]) begin
            b_vld = 1'b1;
            b_idx = idx;
          end
        end
      end
    end
    if (hold || !reset_n) begin
      a_vld = 1'b0;
      b_vld = 1'b0;
    end
  end

  always_comb begin
    rdy = '0;
    if (a_vld) rdy[a_idx] = 1'b1;
    if (b_vld) rdy[b_idx] = 1'b1;
  end

  assign rq.req_ready = rdy;
  assign unserved     = |(rq.req_valid & ~rdy);
  assign last_idx     = b_vld ? b_idx : a_idx;
  assign ptr_nxt      = !a_vld ? ptr : (last_idx == 2'd2) ? 2'd0 : 2'(last_idx + 2'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr       <= 2'd0;
      we3       <= 1'b0;
      wa3       <= 3'd0;
      wd3       <= 8'd0;
      we4       <= 1'b0;
      wa4       <= 3'd0;
      wd4       <= 8'd0;
      stall_cnt <= 8'd0;
    end else begin
      ptr <= ptr_nxt;
      we3 <= a_vld;
      we4 <= b_vld;
      if (a_vld) begin
        wa3 <= addr_v[a_idx];
        wd3 <= data_v[a_idx];
      end
      if (b_vld) begin
        wa4 <= addr_v[b_idx];
        wd4 <= data_v[b_idx];
      end
      if (unserved && stall_cnt != 8'hFF) stall_cnt <= stall_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_wb_sched.sv
// Randomized bench for wb_sched against a queue-based arbitration model,
// plus directed cases for ordering, conflicts, hold, saturation and reset.
module tb_wb_sched;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       hold;
  logic       we3, we4;
  logic [2:0] wa3, wa4;
  logic [7:0] wd3, wd4, stall_cnt;

  wb_sched_if rif ();

  wb_sched dut (
    .clk(clk), .reset_n(reset_n), .rq(rif), .hold(hold),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .we4(we4), .wa4(wa4), .wd4(wd4),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int nerr = 0;
  int nchk = 0;

  logic [2:0] tv;
  logic [2:0] ta [3];
  logic [7:0] td [3];

  int         m_ptr, m_stall;
  logic       m_we3, m_we4;
  logic [2:0] m_wa3, m_wa4;
  logic [7:0] m_wd3, m_wd4;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 3; i++) begin
      rif.req_valid[i]       = tv[i];
      rif.req_addr[3*i +: 3] = ta[i];
      rif.req_data[8*i +: 8] = td[i];
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_stall = 0;
    m_we3 = 0; m_wa3 = 0; m_wd3 = 0;
    m_we4 = 0; m_wa4 = 0; m_wd4 = 0;
  endtask

  // Collect valid requesters in priority order, take the first, and the second
  // only when its destination differs from the first.
  task automatic model_arb(output logic [2:0] rdy, output int ga, output int gb);
    int order[$];
    ga = -1; gb = -1; rdy = 3'b000;
    if (!hold) begin
      for (int k = 0; k < 3; k++)
        if (tv[(m_ptr + k) % 3]) order.push_back((m_ptr + k) % 3);
      if (order.size() > 0) ga = order[0];
      if (order.size() > 1 && ta[order[1]] != ta[ga]) gb = order[1];
      if (ga >= 0) rdy[ga] = 1'b1;
      if (gb >= 0) rdy[gb] = 1'b1;
    end
  endtask

  // Entered at a falling edge; returns at the next falling edge.
  task automatic cyc(output logic [2:0] rdy_o);
    logic [2:0] er;
    int ga, gb;
    drive();
    #1;
    model_arb(er, ga, gb);
    rdy_o = rif.req_ready;
    chk("ready", 32'(rif.req_ready), 32'(er));
    @(posedge clk);
    if ((tv & ~er) != 3'b000 && m_stall < 255) m_stall++;
    m_we3 = (ga >= 0);
    m_we4 = (gb >= 0);
    if (ga >= 0) begin m_wa3 = ta[ga]; m_wd3 = td[ga]; end
    if (gb >= 0) begin m_wa4 = ta[gb]; m_wd4 = td[gb]; end
    if (ga >= 0) m_ptr = ((gb >= 0 ? gb : ga) + 1) % 3;
    #1;
    chk("we3", 32'(we3), 32'(m_we3));
    chk("wa3", 32'(wa3), 32'(m_wa3));
    chk("wd3", 32'(wd3), 32'(m_wd3));
    chk("we4", 32'(we4), 32'(m_we4));
    chk("wa4", 32'(wa4), 32'(m_wa4));
    chk("wd4", 32'(wd4), 32'(m_wd4));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    chk("wconf", 32'(we3 && we4 && (wa3 == wa4)), 32'd0);
    @(negedge clk);
  endtask

  task automatic set3(input logic [2:0] v, input logic [2:0] a0, input logic [2:0] a1,
                      input logic [2:0] a2, input logic [7:0] d0, input logic [7:0] d1,
                      input logic [7:0] d2);
    tv = v;
    ta[0] = a0; ta[1] = a1; ta[2] = a2;
    td[0] = d0; td[1] = d1; td[2] = d2;
  endtask

  initial begin
    logic [2:0] r;
    int         s0;
    reset_n = 1'b0;
    hold    = 1'b0;
    set3(3'b111, 3'd1, 3'd2, 3'd3, 8'h11, 8'h22, 8'h33);
    drive();
    model_reset();
    @(negedge clk);
    #1;
    chk("rst_ready", 32'(rif.req_ready), 32'd0);
    chk("rst_we3", 32'(we3), 32'd0);
    chk("rst_we4", 32'(we4), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Three valid, distinct addresses: two granted, req 2 waits
    cyc(r);
    chk("c1_rdy", 32'(r), 32'b011);
    chk("c1_wa3", 32'(wa3), 32'd1);
    chk("c1_wd3", 32'(wd3), 32'h11);
    chk("c1_wd4", 32'(wd4), 32'h22);
    chk("c1_stall", 32'(stall_cnt), 32'd1);
    tv = 3'b100;
    cyc(r);
    chk("c2_rdy", 32'(r), 32'b100);
    chk("c2_wd3", 32'(wd3), 32'h33);
    chk("c2_we4", 32'(we4), 32'd0);

    // Address conflict: req 1 deferred, then served on port 3
    set3(3'b011, 3'd5, 3'd5, 3'd0, 8'hAA, 8'hBB, 8'h00);
    cyc(r);
    chk("c3_rdy", 32'(r), 32'b001);
    chk("c3_wd3", 32'(wd3), 32'hAA);
    tv = 3'b010;
    cyc(r);
    chk("c4_rdy", 32'(r), 32'b010);
    chk("c4_wd3", 32'(wd3), 32'hBB);

    // Hold for 4 cycles, then pointer (2) must be unchanged
    s0 = int'(stall_cnt);
    hold = 1'b1;
    set3(3'b111, 3'd1, 3'd2, 3'd3, 8'h01, 8'h02, 8'h03);
    repeat (4) begin
      cyc(r);
      chk("hold_rdy", 32'(r), 32'd0);
    end
    chk("hold_stall", 32'(stall_cnt), 32'(s0 + 4));
    hold = 1'b0;
    cyc(r);
    chk("post_hold_rdy", 32'(r), 32'b101);

    // Randomized traffic with stable pending requests
    tv = 3'b000;
    for (int n = 0; n < 400; n++) begin
      hold = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < 3; i++)
        if (!tv[i] && $urandom_range(0, 9) < 6) begin
          tv[i] = 1'b1;
          ta[i] = 3'($urandom_range(0, 3));
          td[i] = 8'($urandom);
        end
      cyc(r);
      for (int i = 0; i < 3; i++)
        if (r[i]) tv[i] = 1'b0;
    end

    // Saturation
    hold = 1'b1;
    set3(3'b111, 3'd1, 3'd2, 3'd3, 8'h44, 8'h55, 8'h66);
    repeat (260) cyc(r);
    chk("sat_stall", 32'(stall_cnt), 32'd255);
    hold = 1'b0;

    // Mid-cycle reset after a grant: outputs clear, nothing emitted later
    cyc(r);
    chk("pre_rst_we3", 32'(we3), 32'd1);
    drive();
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_we3", 32'(we3), 32'd0);
    chk("arst_we4", 32'(we4), 32'd0);
    chk("arst_stall", 32'(stall_cnt), 32'd0);
    chk("arst_ready", 32'(rif.req_ready), 32'd0);
    tv = 3'b000;
    drive();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    cyc(r);
    chk("post_rst_we3", 32'(we3), 32'd0);
    chk("post_rst_we4", 32'(we4), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
